// File: rtl/peak_hist.sv
// peak_hist: pulse-height histogrammer fed by the peak detector.
// Each accepted peak is scaled to a bin index (arithmetic right shift).
// The bin is then incremented by read-modify-write in a dual-port count RAM.
// Port A belongs to the FSM (increment and clear); port B is the host read port.
// Optional feature: define PEAK_HIST_LIVETIME_EN to build the live-time counter.
// Without it, live_time is tied to zero.
module peak_hist #(
    parameter int WD       = 24,
    parameter int BIN_BITS = 10,
    parameter int SHIFT    = 6,
    parameter int CNT_W    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [WD-1:0] peak_in,
    input  logic                 peak_valid,
    output logic                 read_shift,
    input  logic                 clear,
    output logic                 busy,
    input  logic                 rd_en,
    input  logic [BIN_BITS-1:0]  rd_addr,
    output logic [CNT_W-1:0]     rd_data,
    output logic                 rd_valid,
    output logic [CNT_W-1:0]     events,
    output logic [CNT_W-1:0]     underflows,
    output logic [CNT_W-1:0]     overflows,
    output logic [CNT_W-1:0]     live_time
);

    localparam int NBINS = 1 << BIN_BITS;

    typedef enum logic [1:0] {
        CLR  = 2'd0,
        IDLE = 2'd1,
        RD   = 2'd2,
        WR   = 2'd3
    } state_t;

    state_t state, state_next;

    logic                       clear_pend;
    logic [BIN_BITS-1:0]        clr_addr;
    logic                       clr_last;
    logic                       enter_clr;

    logic signed [WD-1:0]       bin_full;
    logic                       is_under;
    logic                       is_over;
    logic                       in_range;
    logic                       accept;

    logic [BIN_BITS-1:0]        bin_p0;
    logic [CNT_W-1:0]           q_p1;

    logic                       ram_we;
    logic [BIN_BITS-1:0]        ram_waddr;
    logic [CNT_W-1:0]           ram_wdata;

    logic [CNT_W-1:0]           mem [NBINS];

    // Counts stick at all-ones rather than wrapping to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
        if (&x) begin
            return x;
        end
        return x + CNT_W'(1);
    endfunction

    // Bin mapping and classification of the incoming peak.
    // A negative peak is only an underflow, never an overflow.
    assign bin_full = peak_in >>> SHIFT;
    assign is_under = peak_in[WD-1];
    assign is_over  = ~is_under & (|bin_full[WD-1:BIN_BITS]);
    assign in_range = ~is_under & ~is_over;
    assign accept   = read_shift & peak_valid;

    assign clr_last  = &clr_addr;
    assign enter_clr = (state != CLR) && (state_next == CLR);

    // State register: reset parks the FSM in CLR so the RAM is always wiped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= CLR;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    // A pending clear is honoured only from IDLE, so an increment in flight always completes.
    always_comb begin
        state_next = state;
        case (state)
            CLR: begin
                if (clr_last) begin
                    state_next = IDLE;
                end
            end
            IDLE: begin
                if (clear_pend) begin
                    state_next = CLR;
                end else if (accept && in_range) begin
                    state_next = RD;
                end
            end
            RD:      state_next = WR;
            WR:      state_next = IDLE;
            default: state_next = CLR;
        endcase
    end

    // FSM outputs: handshake flags and the port A write controls.
    always_comb begin
        busy       = (state != IDLE);
        read_shift = (state == IDLE) && !clear_pend;
        ram_we     = 1'b0;
        ram_waddr  = clr_addr;
        ram_wdata  = '0;
        case (state)
            CLR: begin
                ram_we = 1'b1;
            end
            WR: begin
                ram_we    = 1'b1;
                ram_waddr = bin_p0;
                ram_wdata = sat_inc(q_p1);
            end
            default: begin
                ram_we = 1'b0;
            end
        endcase
    end

    // Clear request latch.
    // It is set outside CLR and dropped once the sweep reaches the last bin.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clear_pend <= 1'b0;
        end else if (state == CLR) begin
            if (clr_last) begin
                clear_pend <= 1'b0;
            end
        end else if (clear) begin
            clear_pend <= 1'b1;
        end
    end

    // Clear sweep address: advances through CLR and is held at 0 otherwise.
    // Every sweep therefore starts at bin 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_addr <= '0;
        end else if (state == CLR) begin
            clr_addr <= clr_addr + BIN_BITS'(1);
        end else begin
            clr_addr <= '0;
        end
    end

    // Stage p0: latch the in-range bin index at acceptance.
    always_ff @(posedge clk) begin
        if (accept && in_range) begin
            bin_p0 <= bin_full[BIN_BITS-1:0];
        end
    end

    // Stage p1: synchronous port A read of the current bin count.
    always_ff @(posedge clk) begin
        if (state == RD) begin
            q_p1 <= mem[bin_p0];
        end
    end

    // Port A write: clear sweep or saturated increment.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_waddr] <= ram_wdata;
        end
    end

    // Port B host read.
    // It is read-first, so a same-cycle port A write to that bin returns the old count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= mem[rd_addr];
            end
        end
    end

    // Event totals: zeroed on entry to CLR, otherwise bumped on each accepted peak.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            events     <= '0;
            underflows <= '0;
            overflows  <= '0;
        end else if (enter_clr) begin
            events     <= '0;
            underflows <= '0;
            overflows  <= '0;
        end else if (accept) begin
            events <= sat_inc(events);
            if (is_under) begin
                underflows <= sat_inc(underflows);
            end
            if (is_over) begin
                overflows <= sat_inc(overflows);
            end
        end
    end

`ifdef PEAK_HIST_LIVETIME_EN
    // Live time: counts every cycle outside CLR; it restarts from zero on entry to CLR.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            live_time <= '0;
        end else if (enter_clr) begin
            live_time <= '0;
        end else if (state != CLR) begin
            live_time <= sat_inc(live_time);
        end
    end
`else
    assign live_time = '0;
`endif

endmodule

// File: tb/tb_peak_hist.sv
// Directed testbench for peak_hist.
// The count width is narrowed to 8 bits so that saturation can be reached quickly.
module tb_peak_hist;

    localparam int WD       = 24;
    localparam int BIN_BITS = 10;
    localparam int SHIFT    = 6;
    localparam int CNT_W    = 8;
    localparam int NBINS    = 1 << BIN_BITS;

    logic                 clk;
    logic                 rst;
    logic signed [WD-1:0] peak_in;
    logic                 peak_valid;
    logic                 read_shift;
    logic                 clear;
    logic                 busy;
    logic                 rd_en;
    logic [BIN_BITS-1:0]  rd_addr;
    logic [CNT_W-1:0]     rd_data;
    logic                 rd_valid;
    logic [CNT_W-1:0]     events;
    logic [CNT_W-1:0]     underflows;
    logic [CNT_W-1:0]     overflows;
    logic [CNT_W-1:0]     live_time;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int cyc_clr_done = 0;

    peak_hist #(
        .WD(WD), .BIN_BITS(BIN_BITS), .SHIFT(SHIFT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .peak_in(peak_in), .peak_valid(peak_valid), .read_shift(read_shift),
        .clear(clear), .busy(busy),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .events(events), .underflows(underflows), .overflows(overflows),
        .live_time(live_time)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_peak(input int v);
        peak_in    = WD'(v);
        peak_valid = 1'b1;
        tick();
        peak_valid = 1'b0;
    endtask

    task automatic wait_idle(output bit timed_out);
        int n;
        n = 0;
        while (!read_shift && n < 3000) begin
            tick();
            n++;
        end
        timed_out = !read_shift;
    endtask

    task automatic host_read(input int a, output logic [CNT_W-1:0] d, output logic v);
        rd_en   = 1'b1;
        rd_addr = BIN_BITS'(a);
        tick();
        rd_en = 1'b0;
        d = rd_data;
        v = rd_valid;
    endtask

    task automatic test_reset();
        logic [CNT_W-1:0] d;
        logic v;
        int bad;
        rst = 1'b1;
        repeat (5) tick();
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy: got %b expected 1", busy); end
        n_checks++; if (read_shift !== 1'b0) begin n_fail++; $display("FAIL reset_read_shift: got %b expected 0", read_shift); end
        n_checks++; if (events !== 0 || underflows !== 0 || overflows !== 0) begin
            n_fail++; $display("FAIL reset_totals: got %0d/%0d/%0d expected 0/0/0", events, underflows, overflows); end
        n_checks++; if (rd_data !== 0 || rd_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_rd: got data %0d valid %b expected 0/0", rd_data, rd_valid); end
        n_checks++; if (live_time !== 0) begin n_fail++; $display("FAIL reset_live_time: got %0d expected 0", live_time); end
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < NBINS; i++) begin
            if (busy !== 1'b1 || read_shift !== 1'b0) bad++;
            tick();
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL reset_clr_window: %0d bad cycles expected 0", bad); end
        n_checks++; if (read_shift !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_idle_after: read_shift %b busy %b expected 1/0", read_shift, busy); end
        cyc_clr_done = cyc;
        host_read(0, d, v);
        n_checks++; if (d !== 0 || v !== 1'b1) begin n_fail++; $display("FAIL reset_bin0: got %0d valid %b expected 0/1", d, v); end
        host_read(NBINS - 1, d, v);
        n_checks++; if (d !== 0) begin n_fail++; $display("FAIL reset_bin1023: got %0d expected 0", d); end
    endtask

    task automatic test_single_peak();
        logic [CNT_W-1:0] d;
        logic v;
        int lowc;
        send_peak(1000);
        n_checks++; if (events !== 1) begin n_fail++; $display("FAIL single_events: got %0d expected 1", events); end
        lowc = 0;
        while (!read_shift && lowc < 10) begin
            lowc++;
            tick();
        end
        n_checks++; if (lowc != 2) begin n_fail++; $display("FAIL single_low_cycles: got %0d expected 2", lowc); end
        host_read(15, d, v);
        n_checks++; if (d !== 1 || v !== 1'b1) begin n_fail++; $display("FAIL single_bin15: got %0d valid %b expected 1/1", d, v); end
        tick();
        n_checks++; if (rd_valid !== 1'b0 || rd_data !== 1) begin
            n_fail++; $display("FAIL single_rd_hold: valid %b data %0d expected 0/1", rd_valid, rd_data); end
    endtask

    task automatic test_collision();
        send_peak(1000);
        tick();
        rd_en   = 1'b1;
        rd_addr = 15;
        tick();
        n_checks++; if (rd_data !== 1 || rd_valid !== 1'b1) begin
            n_fail++; $display("FAIL collision_old: got %0d valid %b expected 1/1", rd_data, rd_valid); end
        n_checks++; if (read_shift !== 1'b1) begin n_fail++; $display("FAIL collision_idle: read_shift %b expected 1", read_shift); end
        tick();
        rd_en = 1'b0;
        n_checks++; if (rd_data !== 2) begin n_fail++; $display("FAIL collision_new: got %0d expected 2", rd_data); end
        n_checks++; if (events !== 2) begin n_fail++; $display("FAIL collision_events: got %0d expected 2", events); end
    endtask

    task automatic test_range();
        logic [CNT_W-1:0] d;
        logic v;
        bit to;
        send_peak(-5);
        n_checks++; if (read_shift !== 1'b1 || underflows !== 1 || overflows !== 0) begin
            n_fail++; $display("FAIL range_under: rs %b under %0d over %0d expected 1/1/0", read_shift, underflows, overflows); end
        send_peak(65536);
        n_checks++; if (read_shift !== 1'b1 || overflows !== 1 || underflows !== 1) begin
            n_fail++; $display("FAIL range_over: rs %b under %0d over %0d expected 1/1/1", read_shift, underflows, overflows); end
        send_peak(65535);
        n_checks++; if (read_shift !== 1'b0) begin n_fail++; $display("FAIL range_top_rd: read_shift %b expected 0", read_shift); end
        wait_idle(to);
        n_checks++; if (to) begin n_fail++; $display("FAIL range_timeout: read_shift %b expected 1", read_shift); end
        host_read(NBINS - 1, d, v);
        n_checks++; if (d !== 1) begin n_fail++; $display("FAIL range_bin1023: got %0d expected 1", d); end
        n_checks++; if (events !== 5) begin n_fail++; $display("FAIL range_events: got %0d expected 5", events); end
    endtask

    task automatic test_saturation();
        logic [CNT_W-1:0] d;
        logic v;
        bit to;
        bit any_to;
        any_to = 1'b0;
        for (int i = 0; i < 253; i++) begin
            send_peak(1000);
            wait_idle(to);
            any_to |= to;
        end
        host_read(15, d, v);
        n_checks++; if (d !== 8'hFF) begin n_fail++; $display("FAIL sat_bin_reach: got %0d expected 255", d); end
        n_checks++; if (events !== 8'hFF) begin n_fail++; $display("FAIL sat_events: got %0d expected 255", events); end
        send_peak(1000);
        wait_idle(to);
        any_to |= to;
        host_read(15, d, v);
        n_checks++; if (d !== 8'hFF) begin n_fail++; $display("FAIL sat_bin_hold: got %0d expected 255", d); end
        n_checks++; if (any_to) begin n_fail++; $display("FAIL sat_timeout: timeout %b expected 0", any_to); end
        n_checks++; if (underflows !== 1 || overflows !== 1) begin
            n_fail++; $display("FAIL sat_others: under %0d over %0d expected 1/1", underflows, overflows); end
    endtask

    task automatic test_clear_during_wr();
        logic [CNT_W-1:0] d;
        logic v;
        int n;
        send_peak(640);
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        n_checks++; if (read_shift !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL clrwr_pend_idle: rs %b busy %b expected 0/0", read_shift, busy); end
        rd_en   = 1'b1;
        rd_addr = 10;
        tick();
        rd_en = 1'b0;
        n_checks++; if (rd_data !== 1) begin n_fail++; $display("FAIL clrwr_bin10_written: got %0d expected 1", rd_data); end
        n_checks++; if (busy !== 1'b1 || events !== 0) begin
            n_fail++; $display("FAIL clrwr_entry: busy %b events %0d expected 1/0", busy, events); end
        n = 0;
        while (busy && n < 3000) begin
            n++;
            tick();
        end
        n_checks++; if (n != NBINS) begin n_fail++; $display("FAIL clrwr_clr_len: got %0d expected %0d", n, NBINS); end
        n_checks++; if (events !== 0 || underflows !== 0 || overflows !== 0) begin
            n_fail++; $display("FAIL clrwr_totals: got %0d/%0d/%0d expected 0/0/0", events, underflows, overflows); end
        host_read(10, d, v);
        n_checks++; if (d !== 0) begin n_fail++; $display("FAIL clrwr_bin10: got %0d expected 0", d); end
        host_read(15, d, v);
        n_checks++; if (d !== 0) begin n_fail++; $display("FAIL clrwr_bin15: got %0d expected 0", d); end
        host_read(NBINS - 1, d, v);
        n_checks++; if (d !== 0) begin n_fail++; $display("FAIL clrwr_bin1023: got %0d expected 0", d); end
    endtask

    task automatic test_clear_with_accept();
        logic [CNT_W-1:0] d;
        logic v;
        bit to;
        clear      = 1'b1;
        peak_in    = WD'(640);
        peak_valid = 1'b1;
        tick();
        clear      = 1'b0;
        peak_valid = 1'b0;
        n_checks++; if (events !== 1 || read_shift !== 1'b0) begin
            n_fail++; $display("FAIL clracc_counted: events %0d rs %b expected 1/0", events, read_shift); end
        wait_idle(to);
        n_checks++; if (to) begin n_fail++; $display("FAIL clracc_timeout: read_shift %b expected 1", read_shift); end
        cyc_clr_done = cyc;
        n_checks++; if (live_time !== 0) begin n_fail++; $display("FAIL clracc_live_zero: got %0d expected 0", live_time); end
        n_checks++; if (events !== 0) begin n_fail++; $display("FAIL clracc_events: got %0d expected 0", events); end
        host_read(10, d, v);
        n_checks++; if (d !== 0) begin n_fail++; $display("FAIL clracc_bin10: got %0d expected 0", d); end
    endtask

    task automatic test_live_time();
        bit to;
        int expect_lt;
        repeat (4) tick();
        send_peak(3000);
        wait_idle(to);
        repeat (3) tick();
`ifdef PEAK_HIST_LIVETIME_EN
        expect_lt = cyc - cyc_clr_done;
`else
        expect_lt = 0;
`endif
        n_checks++; if (live_time !== CNT_W'(expect_lt)) begin
            n_fail++; $display("FAIL live_time: got %0d expected %0d", live_time, expect_lt); end
        n_checks++; if (events !== 1 || to) begin
            n_fail++; $display("FAIL live_events: events %0d timeout %b expected 1/0", events, to); end
    endtask

    initial begin
        rst        = 1'b1;
        peak_in    = '0;
        peak_valid = 1'b0;
        clear      = 1'b0;
        rd_en      = 1'b0;
        rd_addr    = '0;
        test_reset();
        test_single_peak();
        test_collision();
        test_range();
        test_saturation();
        test_clear_during_wr();
        test_clear_with_accept();
        test_live_time();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
